// File: rtl/decoder.sv
// Instruction decoder for the 8-bit core: splits the instruction into fields and
// drives register-file, status and program-counter controls; illegal_op is sticky.
module decoder #(
  parameter int DataWidth         = 8,
  parameter int SEL_WIDTH         = 2,
  parameter int PROGRAM_DataWidth = 16,
  parameter int NumOpCodeBits     = 5,
  parameter int ParamBits         = 8,
  parameter int NumStatusBits     = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PROGRAM_DataWidth-1:0] instruction,
  input  logic [NumStatusBits-1:0]     status,
  output logic [NumOpCodeBits-1:0]     opcode,
  output logic [ParamBits-1:0]         param,
  output logic [DataWidth-1:0]         literal_adr,
  output logic [SEL_WIDTH-1:0]         rd_sel1,
  output logic [SEL_WIDTH-1:0]         rd_sel2,
  output logic                         rd_en1,
  output logic                         rd_en2,
  output logic [SEL_WIDTH-1:0]         wr_sel,
  output logic                         wr_en,
  output logic                         sel_reg_in_alu_decoder,
  output logic                         cnt_wr_en,
  output logic                         add_offset,
  output logic                         stat_wr_en,
  output logic                         stat_reg_in_alu_decoder,
  output logic [NumStatusBits-1:0]     status_out,
  output logic                         illegal_op
);

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_NOT  = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_SHR  = 5'b01000;
  localparam logic [4:0] OP_VAL  = 5'b01001;
  localparam logic [4:0] OP_GOTO = 5'b10000;
  localparam logic [4:0] OP_IFZ  = 5'b10001;
  localparam logic [4:0] OP_IFNZ = 5'b10010;
  localparam logic [4:0] OP_IFEQ = 5'b10011;
  localparam logic [4:0] OP_IFST = 5'b10100;
  localparam logic [4:0] OP_IFGT = 5'b10101;

  logic [SEL_WIDTH-1:0] op1;
  logic [SEL_WIDTH-1:0] op2;
  logic                 reserved;
  logic                 branch_taken;
  logic                 is_branch;
  logic                 unused_bits;

  assign opcode      = instruction[PROGRAM_DataWidth-1 -: NumOpCodeBits];
  assign param       = instruction[ParamBits-1:0];
  assign literal_adr = instruction[DataWidth-1:0];
  assign op1         = instruction[9:8];
  assign op2         = instruction[4:3];

  assign stat_reg_in_alu_decoder = 1'b1;
  assign status_out              = '0;

  // Bit 10 and the low status flags carry no meaning for decode.
  assign unused_bits = ^{instruction[10], status[1:0]};

  always_comb begin
    rd_sel1                = '0;
    rd_sel2                = '0;
    rd_en1                 = 1'b0;
    rd_en2                 = 1'b0;
    wr_sel                 = '0;
    wr_en                  = 1'b0;
    sel_reg_in_alu_decoder = 1'b0;
    cnt_wr_en              = 1'b0;
    add_offset             = 1'b0;
    stat_wr_en             = 1'b0;
    reserved               = 1'b0;
    branch_taken           = 1'b0;
    is_branch              = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        rd_sel1 = op1;  rd_en1 = 1'b1;
        rd_sel2 = op2;  rd_en2 = 1'b1;
        wr_sel  = op1;  wr_en  = 1'b1;
        sel_reg_in_alu_decoder = 1'b1;
        stat_wr_en             = 1'b1;
      end
      OP_NOT: begin
        rd_sel2 = op2;  rd_en2 = 1'b1;
        wr_sel  = op1;  wr_en  = 1'b1;
        sel_reg_in_alu_decoder = 1'b1;
        stat_wr_en             = 1'b1;
      end
      OP_SHL, OP_SHR: begin
        rd_sel1 = op1;  rd_en1 = 1'b1;
        wr_sel  = op1;  wr_en  = 1'b1;
        sel_reg_in_alu_decoder = 1'b1;
        stat_wr_en             = 1'b1;
      end
      OP_VAL: begin
        wr_sel = op1;
        wr_en  = 1'b1;
      end
      OP_GOTO: cnt_wr_en = 1'b1;
      OP_IFZ:  begin is_branch = 1'b1; branch_taken = status[2];  end
      OP_IFNZ: begin is_branch = 1'b1; branch_taken = !status[2]; end
      OP_IFEQ: begin is_branch = 1'b1; branch_taken = status[3];  end
      OP_IFST: begin is_branch = 1'b1; branch_taken = status[4];  end
      OP_IFGT: begin is_branch = 1'b1; branch_taken = status[5];  end
      default: reserved = 1'b1;
    endcase
    if (is_branch) begin
      cnt_wr_en  = branch_taken;
      add_offset = branch_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op <= 1'b0;
    end else if (reserved) begin
      illegal_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: directed cases plus random instructions/status checked
// against a rule-level reference model, including the sticky illegal_op flag.
module tb_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instruction = '0;
  logic [5:0]  status = '0;
  logic [4:0]  opcode;
  logic [7:0]  param, literal_adr;
  logic [1:0]  rd_sel1, rd_sel2, wr_sel;
  logic        rd_en1, rd_en2, wr_en, sel_reg_in_alu_decoder;
  logic        cnt_wr_en, add_offset, stat_wr_en, stat_reg_in_alu_decoder;
  logic [5:0]  status_out;
  logic        illegal_op;

  int checks = 0;
  int failures = 0;
  logic exp_ill = 1'b0;

  decoder dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .status(status),
    .opcode(opcode), .param(param), .literal_adr(literal_adr),
    .rd_sel1(rd_sel1), .rd_sel2(rd_sel2), .rd_en1(rd_en1), .rd_en2(rd_en2),
    .wr_sel(wr_sel), .wr_en(wr_en), .sel_reg_in_alu_decoder(sel_reg_in_alu_decoder),
    .cnt_wr_en(cnt_wr_en), .add_offset(add_offset), .stat_wr_en(stat_wr_en),
    .stat_reg_in_alu_decoder(stat_reg_in_alu_decoder), .status_out(status_out),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] rs1, rs2;
    logic       re1, re2;
    logic [1:0] ws;
    logic       we, sri, cwe, aoff, swe;
  } ctl_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (instr=%04h status=%02h)", tag, got, exp,
               instruction, status);
    end
  endtask

  function automatic logic is_reserved(input logic [15:0] ins);
    int op;
    op = int'(ins[15:11]);
    return (op >= 10 && op <= 15) || op >= 22;
  endfunction

  function automatic ctl_t model(input logic [15:0] ins, input logic [5:0] st);
    ctl_t c;
    int   op;
    logic alu_op, reads1, reads2;
    logic conds [5];
    c  = '0;
    op = int'(ins[15:11]);
    alu_op = (op >= 1 && op <= 8);
    reads1 = alu_op && op != 5;
    reads2 = (op >= 1 && op <= 6);
    if (alu_op || op == 9) begin c.ws = ins[9:8]; c.we = 1'b1; end
    c.sri = alu_op;
    c.swe = alu_op;
    if (reads1) begin c.rs1 = ins[9:8]; c.re1 = 1'b1; end
    if (reads2) begin c.rs2 = ins[4:3]; c.re2 = 1'b1; end
    if (op == 16) c.cwe = 1'b1;
    conds = '{st[2], !st[2], st[3], st[4], st[5]};
    if (op >= 17 && op <= 21) begin
      c.cwe  = conds[op-17];
      c.aoff = conds[op-17];
    end
    return c;
  endfunction

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [1:0] op1, input logic [7:0] imm);
    return {op, 1'b0, op1, imm};
  endfunction

  task automatic check_comb();
    ctl_t got, exp;
    got = '{rs1: rd_sel1, rs2: rd_sel2, re1: rd_en1, re2: rd_en2, ws: wr_sel,
            we: wr_en, sri: sel_reg_in_alu_decoder, cwe: cnt_wr_en, aoff: add_offset,
            swe: stat_wr_en};
    exp = model(instruction, status);
    check_eq("opcode", 32'(opcode), 32'(instruction[15:11]));
    check_eq("param", 32'(param), 32'(instruction[7:0]));
    check_eq("literal_adr", 32'(literal_adr), 32'(instruction[7:0]));
    check_eq("controls", 32'(got), 32'(exp));
    check_eq("stat_reg_in", 32'(stat_reg_in_alu_decoder), 32'd1);
    check_eq("status_out", 32'(status_out), 32'd0);
  endtask

  task automatic apply(input logic [15:0] ins, input logic [5:0] st);
    @(negedge clk);
    instruction = ins;
    status      = st;
    #1 check_comb();
    @(posedge clk);
    if (rst_n && is_reserved(ins)) exp_ill = 1'b1;
    #1 check_eq("illegal_op", 32'(illegal_op), 32'(exp_ill));
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 check_eq("illegal_async_clr", 32'(illegal_op), 32'd0);
    exp_ill = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    check_comb();
    check_eq("reset_illegal", 32'(illegal_op), 32'd0);
    check_eq("reset_wr_en", 32'(wr_en), 32'd0);
    #1 rst_n = 1'b1;

    apply(16'h0000, 6'h00);
    apply(mk(5'b00001, 2'b01, 8'h10), 6'h00);
    check_eq("add_rd_sel2", 32'(rd_sel2), 32'h2);
    apply(mk(5'b00101, 2'b10, 8'h00), 6'h00);
    check_eq("not_rd_en1", 32'(rd_en1), 32'd0);
    apply(mk(5'b01001, 2'b11, 8'hA5), 6'h00);
    check_eq("val_param", 32'(param), 32'hA5);
    check_eq("val_sel_reg_in", 32'(sel_reg_in_alu_decoder), 32'd0);
    apply(mk(5'b10000, 2'b00, 8'h3F), 6'h00);
    check_eq("goto_cnt_wr_en", 32'(cnt_wr_en), 32'd1);
    apply(mk(5'b10001, 2'b00, 8'h05), 6'h00);
    check_eq("ifz_not_taken", 32'(cnt_wr_en), 32'd0);
    apply(mk(5'b10001, 2'b00, 8'h05), 6'h04);
    check_eq("ifz_taken", 32'({cnt_wr_en, add_offset}), 32'h3);
    apply(mk(5'b10010, 2'b00, 8'h05), 6'h04);
    check_eq("ifnz_not_taken", 32'(cnt_wr_en), 32'd0);
    apply(mk(5'b10011, 2'b00, 8'h05), 6'h08);
    check_eq("ifeq_taken", 32'(add_offset), 32'd1);
    apply(mk(5'b10011, 2'b00, 8'h05), 6'h00);
    apply(mk(5'b01010, 2'b00, 8'h00), 6'h00);
    check_eq("illegal_set", 32'(illegal_op), 32'd1);
    apply(16'h0000, 6'h00);
    check_eq("illegal_sticky", 32'(illegal_op), 32'd1);
    pulse_reset();

    for (int i = 0; i < 400; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if ($urandom_range(0, 3) != 0)
        ins[15:11] = 5'($urandom_range(0, 9) + (($urandom_range(0, 1) == 1) ? 16 : 0)) ;
      if (ins[15:11] > 5'd25) ins[15:11] = 5'($urandom_range(16, 21));
      apply(ins, 6'($urandom));
      if (i % 16 == 15) pulse_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/decoder.md
# decoder

Combinational instruction decoder for the 8-bit CPU core, between program memory and the register file / ALU / program counter. Splits each 16-bit instruction into opcode and operand fields. Generates register-file read/write selects and enables, the register-input mux select, status-register controls and program-counter load controls, including conditional relative branches on status flags. One registered output, a sticky illegal-opcode flag, is the only clocked logic.

## Interface
Parameters:
- DataWidth, 8, data/address width (literal_adr)
- SEL_WIDTH, 2, register-select width
- PROGRAM_DataWidth, 16, instruction width
- NumOpCodeBits, 5, opcode width
- ParamBits, 8, immediate width
- NumStatusBits, 6, status-register width

Ports:
- clk  in  1  clock; only used by illegal_op
- rst_n  in  1  asynchronous, active-low reset
- instruction  in  16  current instruction
- status  in  6  status register; [2]=zero, [3]=equal, [4]=smaller, [5]=greater
- opcode  out  5  instruction[15:11]
- param  out  8  instruction[7:0]
- literal_adr  out  8  instruction[7:0]
- rd_sel1, rd_sel2  out  2  register-file read selects
- rd_en1, rd_en2  out  1  read enables
- wr_sel  out  2  register-file write select
- wr_en  out  1  register-file write enable
- sel_reg_in_alu_decoder  out  1  register input source: 1=ALU, 0=decoder (param)
- cnt_wr_en  out  1  program-counter load enable
- add_offset  out  1  1=PC adds literal_adr as relative offset, 0=absolute load
- stat_wr_en  out  1  status-register write enable
- stat_reg_in_alu_decoder  out  1  status source select; constant 1 (ALU)
- status_out  out  6  decoder-supplied status value; constant 0
- illegal_op  out  1  sticky reserved-opcode flag

## Operation
Instruction fields:
- op1 = instruction[9:8]
- op2 = instruction[4:3]
- imm = instruction[7:0]
- Bit 10 is ignored.
- opcode, param and literal_adr are always driven from their fields, for every opcode.

Default for every control output not listed under an opcode: 0, selects 00.

Per opcode:
- NOP 00000: all defaults.
- ADD 00001, SUB 00010, AND 00011, OR 00100, XOR 00110:
  - rd_sel1=op1, rd_en1=1; rd_sel2=op2, rd_en2=1
  - wr_sel=op1, wr_en=1
  - sel_reg_in_alu_decoder=1, stat_wr_en=1
- NOT 00101:
  - rd_sel2=op2, rd_en2=1; rd_sel1=00, rd_en1=0
  - wr_sel=op1, wr_en=1
  - sel_reg_in_alu_decoder=1, stat_wr_en=1
- SHL 00111, SHR 01000:
  - rd_sel1=op1, rd_en1=1; rd_en2=0
  - wr_sel=op1, wr_en=1
  - sel_reg_in_alu_decoder=1, stat_wr_en=1
  - The ALU takes the shift amount from param.
- VAL 01001:
  - wr_sel=op1, wr_en=1
  - sel_reg_in_alu_decoder=0 (param written)
  - no reads, stat_wr_en=0
- GOTO 10000: cnt_wr_en=1, add_offset=0.
- Conditional branches: when the condition is true, cnt_wr_en=1 and add_offset=1; when false, both are 0. No register or status writes.
  - IFZ 10001: status[2]
  - IFNZ 10010: !status[2]
  - IFEQ 10011: status[3]
  - IFST 10100: status[4]
  - IFGT 10101: status[5]
- Reserved opcodes (01010–01111, 10110–11111): decode as NOP; set illegal_op.

Constant outputs: stat_reg_in_alu_decoder=1 and status_out=000000 for all inputs.

## Timing
- All decode outputs are purely combinational from instruction and status. No latency; valid within the same delta/settling time.
- illegal_op:
  - Set on a rising clk edge when the current opcode is reserved.
  - Holds (sticky) until reset.
  - Reset value 0; async clear on rst_n low, including mid-operation.
- Reset has no effect on combinational outputs.
- A status change with an unchanged branch instruction immediately updates cnt_wr_en and add_offset.

## Test plan
- instruction=0, status=0:
  - stat_wr_en=0, status_out=0, stat_reg_in_alu_decoder=1, all enables 0
- ADD, op1=01, op2=10:
  - rd_sel1=01, rd_sel2=10, both rd_en=1
  - wr_sel=01, wr_en=1, sel_reg_in=1, stat_wr_en=1, add_offset=0
- NOT, op1=10, op2=00:
  - rd_en1=0, rd_en2=1, rd_sel1=rd_sel2=00, wr_sel=10
- VAL, imm=A5, op1=11:
  - param=A5, wr_sel=11, wr_en=1, sel_reg_in=0, rd_en both 0, stat_wr_en=0
- Sequence GOTO imm=3F, then IFZ:
  - GOTO: cnt_wr_en=1, literal_adr=3F, add_offset=0, wr_en=0
  - IFZ with status[2]=0: cnt_wr_en=0, add_offset=0
  - IFZ with status[2]=1: cnt_wr_en=1, add_offset=1
- Branch conditions and illegal_op:
  - IFNZ with status[2]=1: no branch
  - IFEQ with status[3]=1: branch; with status[3]=0: no branch
  - Reserved opcode 01010 plus a clk edge: illegal_op=1; rst_n low clears it asynchronously.
